// File: rtl/nios2_mult_pkg.sv
// Shared definitions for the sequenced 32x32 multiplier: op codes, FSM states,
// and the partial-product index/alignment table.
package nios2_mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIX,
    DONE
  } state_t;

  // Issue order: aL*bL, aL*bH, aH*bL, aH*bH
  localparam logic [1:0] IDX_LL = 2'd0;
  localparam logic [1:0] IDX_LH = 2'd1;
  localparam logic [1:0] IDX_HL = 2'd2;
  localparam logic [1:0] IDX_HH = 2'd3;

  localparam int PP_SHIFT_LL = 0;
  localparam int PP_SHIFT_LH = 16;
  localparam int PP_SHIFT_HL = 16;
  localparam int PP_SHIFT_HH = 32;

  function automatic int pp_shift(input logic [1:0] idx);
    case (idx)
      IDX_LL:  return PP_SHIFT_LL;
      IDX_LH:  return PP_SHIFT_LH;
      IDX_HL:  return PP_SHIFT_HL;
      default: return PP_SHIFT_HH;
    endcase
  endfunction

  function automatic logic [63:0] pp_align(input logic [1:0] idx, input logic [31:0] p);
    return {32'h0, p} << pp_shift(idx);
  endfunction

endpackage

// File: rtl/nios2_mult_lat_pipe.sv
// MUL_LAT-deep {valid, idx} delay line that tags multiplier returns with the
// partial-product index they belong to.
module nios2_mult_lat_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       out_valid,
  output logic [1:0] out_idx,
  output logic       pending
);

  localparam logic [LAT-1:0] PEND_MASK = LAT'((64'd1 << (LAT - 1)) - 64'd1);

  logic [LAT-1:0] valid_reg;
  logic [1:0]     idx_reg [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < LAT; i++) idx_reg[i] <= '0;
    end else if (clr) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      idx_reg[0]   <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        idx_reg[i]   <= idx_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[LAT-1];
  assign out_idx   = idx_reg[LAT-1];
  // Entries still behind the output stage; once clear, the current return is the last.
  assign pending   = |(valid_reg & PEND_MASK);

endmodule

// File: rtl/nios2_mult_seq.sv
// Sequences Nios II MUL/MULX* onto one shared registered 16x16 unsigned multiplier,
// one partial product per cycle, with signed correction for the high-word ops.
module nios2_mult_seq
  import nios2_mult_pkg::*;
#(
  parameter int    MUL_LAT    = 1,
  parameter string DEV_FAMILY = "MAX10"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

  if (MUL_LAT < 1 || MUL_LAT > 3 || DEV_FAMILY == "") begin : g_bad_param
    $error("nios2_mult_seq: MUL_LAT must be 1..3 and DEV_FAMILY non-empty");
  end

  state_t      state_reg, state_next;
  logic [63:0] acc_reg, acc_next;
  logic [1:0]  idx_reg, idx_next;
  logic [1:0]  op_reg, op_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;

  logic        ret_valid;
  logic [1:0]  ret_idx;
  logic        ret_pending;
  logic        last_issue;
  logic [63:0] ret_term;
  logic [63:0] fix_term;

  nios2_mult_lat_pipe #(
    .LAT(MUL_LAT)
  ) u_lat_pipe (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush),
    .in_valid (mul_en),
    .in_idx   (idx_reg),
    .out_valid(ret_valid),
    .out_idx  (ret_idx),
    .pending  (ret_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      idx_reg   <= IDX_LL;
      op_reg    <= OP_MUL;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    ret_term   = ret_valid ? pp_align(ret_idx, mul_p) : 64'h0;
    last_issue = (idx_reg == IDX_HH) || (op_reg == OP_MUL && idx_reg == IDX_HL);

    // Unsigned product minus sign-weighted cross terms gives the signed product mod 2^64.
    fix_term = 64'h0;
    if (a_reg[31] && (op_reg == OP_MULXSS || op_reg == OP_MULXSU))
      fix_term = fix_term + {b_reg, 32'h0};
    if (b_reg[31] && op_reg == OP_MULXSS)
      fix_term = fix_term + {a_reg, 32'h0};

    case (state_reg)
      IDLE: begin
        if (req_valid && !flush) begin
          a_next     = req_a;
          b_next     = req_b;
          op_next    = req_op;
          acc_next   = 64'h0;
          idx_next   = IDX_LL;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        acc_next = acc_reg + ret_term;
        if (last_issue) state_next = DRAIN;
        else            idx_next   = idx_reg + 2'd1;
      end
      DRAIN: begin
        acc_next = acc_reg + ret_term;
        if (!ret_pending) state_next = (op_reg == OP_MUL) ? DONE : FIX;
      end
      FIX: begin
        acc_next   = acc_reg - fix_term;
        state_next = DONE;
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush && state_reg != IDLE) state_next = IDLE;
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == DONE);
  assign resp_data  = (op_reg == OP_MUL) ? acc_reg[31:0] : acc_reg[63:32];
  assign mul_en     = (state_reg == ISSUE);
  // Operands follow the latched sources, so they hold still while no op is running.
  assign mul_a      = idx_reg[1] ? a_reg[31:16] : a_reg[15:0];
  assign mul_b      = idx_reg[0] ? b_reg[31:16] : b_reg[15:0];

endmodule
